avmm_arbiter_2m: RTL and testbench

- Two-master to one-slave Avalon-MM arbiter for sharing one 32-bit slave window between two sub-CPU mm bridge masters.
- Each upstream side is an Avalon-MM slave port: 10-bit word address, burstcount fixed at 1, pipelined reads with readdatavalid.
- One transaction is in flight at a time. Round-robin grant. Read responses are routed back to the master that issued them.
- Sits between the sub-CPU bridge outputs and the shared peripheral/memory interconnect.

---
 rtl/avmm_arbiter_2m_if.sv | 26 ++
 rtl/avmm_arbiter_2m.sv | 177 +++++++++++++++++
 tb/tb_avmm_arbiter_2m.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/avmm_arbiter_2m_if.sv
// Single-beat Avalon-MM bus bundle used for the arbiter's two upstream ports and its shared downstream port.
interface avmm_arbiter_2m_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                burstcount;
    logic                debugaccess;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable, burstcount, debugaccess,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable, burstcount, debugaccess,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avmm_arbiter_2m.sv
// Two-master to one-slave Avalon-MM arbiter: round-robin, one transaction in flight, read responses routed back.
// Optional read-response watchdog with sticky timeout_flag is enabled by defining ARB_TIMEOUT_EN.
module avmm_arbiter_2m #(
    parameter int                ADDR_W         = 10,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    avmm_arbiter_2m_if.slave  s0,
    avmm_arbiter_2m_if.slave  s1,
    avmm_arbiter_2m_if.master m0
`ifdef ARB_TIMEOUT_EN
    ,
    output logic             timeout_flag
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CMD    = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;

    logic [1:0]          state;
    logic                grant;
    logic                last;
    logic [ADDR_W-1:0]   cmd_address;
    logic                cmd_read;
    logic                cmd_write;
    logic [DATA_W-1:0]   cmd_writedata;
    logic [DATA_W/8-1:0] cmd_byteenable;
    logic                cmd_debugaccess;
    logic [DATA_W-1:0]   rdata0;
    logic [DATA_W-1:0]   rdata1;
    logic                rvalid0;
    logic                rvalid1;

    logic                req0;
    logic                req1;
    logic                next_grant;
    logic                accept;
    logic                timed_out;
    logic                resp_fire;
    logic [DATA_W-1:0]   resp_data;
    logic [ADDR_W-1:0]   sel_address;
    logic                sel_read;
    logic                sel_write;
    logic [DATA_W-1:0]   sel_writedata;
    logic [DATA_W/8-1:0] sel_byteenable;
    logic                sel_debugaccess;
    logic                unused_burst;

    assign req0 = s0.read | s0.write;
    assign req1 = s1.read | s1.write;

    // On a tie the master that did not win last time is granted.
    assign next_grant = (req0 && req1) ? ~last : req1;

    assign sel_address     = next_grant ? s1.address     : s0.address;
    assign sel_read        = next_grant ? s1.read        : s0.read;
    assign sel_write       = next_grant ? s1.write       : s0.write;
    assign sel_writedata   = next_grant ? s1.writedata   : s0.writedata;
    assign sel_byteenable  = next_grant ? s1.byteenable  : s0.byteenable;
    assign sel_debugaccess = next_grant ? s1.debugaccess : s0.debugaccess;

    assign accept    = (state == CMD) && !m0.waitrequest;
    assign resp_fire = (state == RDWAIT) && (m0.readdatavalid || timed_out);
    assign resp_data = m0.readdatavalid ? m0.readdata : TIMEOUT_DATA;

    // Burstcount is always 1 on this bus, so the upstream value carries no information.
    assign unused_burst = s0.burstcount ^ s1.burstcount;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state           <= IDLE;
            grant           <= 1'b0;
            last            <= 1'b1;
            cmd_address     <= '0;
            cmd_read        <= 1'b0;
            cmd_write       <= 1'b0;
            cmd_writedata   <= '0;
            cmd_byteenable  <= '0;
            cmd_debugaccess <= 1'b0;
            rdata0          <= '0;
            rdata1          <= '0;
            rvalid0         <= 1'b0;
            rvalid1         <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant           <= next_grant;
                        last            <= next_grant;
                        cmd_address     <= sel_address;
                        cmd_read        <= sel_read;
                        cmd_write       <= sel_write & ~sel_read;
                        cmd_writedata   <= sel_writedata;
                        cmd_byteenable  <= sel_byteenable;
                        cmd_debugaccess <= sel_debugaccess;
                        state           <= CMD;
                    end
                end
                CMD: begin
                    if (accept) begin
                        cmd_read  <= 1'b0;
                        cmd_write <= 1'b0;
                        state     <= cmd_read ? RDWAIT : IDLE;
                    end
                end
                RDWAIT: begin
                    if (resp_fire) begin
                        if (grant) begin
                            rdata1  <= resp_data;
                            rvalid1 <= 1'b1;
                        end else begin
                            rdata0  <= resp_data;
                            rvalid0 <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int               CNT_W        = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_count;

    assign timed_out = (state == RDWAIT) && !m0.readdatavalid && (wd_count == TIMEOUT_LAST);

    // Watchdog restarts on every read accept; the flag stays set until some master writes.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wd_count     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (accept) begin
                wd_count <= '0;
            end else if (state == RDWAIT) begin
                wd_count <= wd_count + 1'b1;
            end
            if (timed_out) begin
                timeout_flag <= 1'b1;
            end else if (accept && cmd_write) begin
                timeout_flag <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign m0.address     = cmd_address;
    assign m0.read        = cmd_read;
    assign m0.write       = cmd_write;
    assign m0.writedata   = cmd_writedata;
    assign m0.byteenable  = cmd_byteenable;
    assign m0.burstcount  = 1'b1;
    assign m0.debugaccess = cmd_debugaccess;

    assign s0.waitrequest   = ~(accept & ~grant);
    assign s1.waitrequest   = ~(accept & grant);
    assign s0.readdata      = rdata0;
    assign s1.readdata      = rdata1;
    assign s0.readdatavalid = rvalid0;
    assign s1.readdatavalid = rvalid1;

endmodule

// File: tb/tb_avmm_arbiter_2m.sv
// Directed self-checking bench for avmm_arbiter_2m; covers the ARB_TIMEOUT_EN watchdog when that macro is defined.
module tb_avmm_arbiter_2m;

    logic clk_clk = 1'b0;
    logic reset_reset_n;
    int   checks   = 0;
    int   failures = 0;
`ifdef ARB_TIMEOUT_EN
    logic timeout_flag;
`endif

    avmm_arbiter_2m_if #(.ADDR_W(10), .DATA_W(32)) s0_bus ();
    avmm_arbiter_2m_if #(.ADDR_W(10), .DATA_W(32)) s1_bus ();
    avmm_arbiter_2m_if #(.ADDR_W(10), .DATA_W(32)) m0_bus ();

    avmm_arbiter_2m #(
        .ADDR_W         (10),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .s0            (s0_bus),
        .s1            (s1_bus),
        .m0            (m0_bus)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_flag  (timeout_flag)
`endif
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk_clk);
    endtask

    task automatic apply_stimulus(input logic who, input logic rd, input logic wr, input logic [9:0] addr,
                                  input logic [31:0] data, input logic [3:0] be, input logic dbg);
        if (who) begin
            s1_bus.read = rd; s1_bus.write = wr; s1_bus.address = addr;
            s1_bus.writedata = data; s1_bus.byteenable = be; s1_bus.debugaccess = dbg;
        end else begin
            s0_bus.read = rd; s0_bus.write = wr; s0_bus.address = addr;
            s0_bus.writedata = data; s0_bus.byteenable = be; s0_bus.debugaccess = dbg;
        end
    endtask

    task automatic clear_master(input logic who);
        apply_stimulus(who, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic drive_slave(input logic wreq, input logic rdv, input logic [31:0] rdata);
        m0_bus.waitrequest   = wreq;
        m0_bus.readdatavalid = rdv;
        m0_bus.readdata      = rdata;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        step();
        step();
        reset_reset_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_s0_wait"},  32'(s0_bus.waitrequest),   32'd1);
        check_output({tag, "_s1_wait"},  32'(s1_bus.waitrequest),   32'd1);
        check_output({tag, "_s0_rdv"},   32'(s0_bus.readdatavalid), 32'd0);
        check_output({tag, "_s1_rdv"},   32'(s1_bus.readdatavalid), 32'd0);
        check_output({tag, "_s0_rdata"}, s0_bus.readdata,           32'd0);
        check_output({tag, "_s1_rdata"}, s1_bus.readdata,           32'd0);
        check_output({tag, "_m0_read"},  32'(m0_bus.read),          32'd0);
        check_output({tag, "_m0_write"}, 32'(m0_bus.write),         32'd0);
        check_output({tag, "_m0_addr"},  32'(m0_bus.address),       32'd0);
        check_output({tag, "_m0_wdata"}, m0_bus.writedata,          32'd0);
        check_output({tag, "_m0_be"},    32'(m0_bus.byteenable),    32'd0);
        check_output({tag, "_m0_dbg"},   32'(m0_bus.debugaccess),   32'd0);
        check_output({tag, "_m0_burst"}, 32'(m0_bus.burstcount),    32'd1);
`ifdef ARB_TIMEOUT_EN
        check_output({tag, "_tflag"},    32'(timeout_flag),         32'd0);
`endif
    endtask

    // Entered one cycle after the grant with a zero-wait slave; returns with the response visible.
    task automatic serve_read(input string tag, input logic who, input logic [9:0] addr, input logic [31:0] data);
        check_output({tag, "_m0_read"},    32'(m0_bus.read),    32'd1);
        check_output({tag, "_m0_addr"},    32'(m0_bus.address), 32'(addr));
        check_output({tag, "_own_wait"},   32'(who ? s1_bus.waitrequest : s0_bus.waitrequest), 32'd0);
        check_output({tag, "_other_wait"}, 32'(who ? s0_bus.waitrequest : s1_bus.waitrequest), 32'd1);
        clear_master(who);
        step();
        check_output({tag, "_m0_read_drop"}, 32'(m0_bus.read), 32'd0);
        drive_slave(1'b0, 1'b1, data);
        step();
        check_output({tag, "_own_rdv"},    32'(who ? s1_bus.readdatavalid : s0_bus.readdatavalid), 32'd1);
        check_output({tag, "_own_rdata"},  who ? s1_bus.readdata : s0_bus.readdata, data);
        check_output({tag, "_other_rdv"},  32'(who ? s0_bus.readdatavalid : s1_bus.readdatavalid), 32'd0);
        drive_slave(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset_reset_n = 1'b0;
        clear_master(1'b0);
        clear_master(1'b1);
        s0_bus.burstcount = 1'b1;
        s1_bus.burstcount = 1'b1;
        drive_slave(1'b0, 1'b0, 32'h0);
        step();
        step();
        check_reset_values("rst");
        reset_reset_n = 1'b1;
        step();

        // Single zero-wait write from s0
        check_output("t1_s0_wait_idle", 32'(s0_bus.waitrequest), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 10'h010, 32'h1234_5678, 4'hF, 1'b1);
        step();
        check_output("t1_m0_write", 32'(m0_bus.write),       32'd1);
        check_output("t1_m0_read",  32'(m0_bus.read),        32'd0);
        check_output("t1_m0_addr",  32'(m0_bus.address),     32'h010);
        check_output("t1_m0_wdata", m0_bus.writedata,        32'h1234_5678);
        check_output("t1_m0_be",    32'(m0_bus.byteenable),  32'hF);
        check_output("t1_m0_dbg",   32'(m0_bus.debugaccess), 32'd1);
        check_output("t1_s0_wait",  32'(s0_bus.waitrequest), 32'd0);
        check_output("t1_s1_wait",  32'(s1_bus.waitrequest), 32'd1);
        clear_master(1'b0);
        step();
        check_output("t1_m0_write_drop", 32'(m0_bus.write),       32'd0);
        check_output("t1_s0_wait_after", 32'(s0_bus.waitrequest), 32'd1);

        // Simultaneous reads after reset: s0 wins, then s1
        do_reset();
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'h020, 32'h0, 4'hF, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 10'h030, 32'h0, 4'hF, 1'b0);
        step();
        serve_read("t2a", 1'b0, 10'h020, 32'h1111_1111);
        step();
        serve_read("t2b", 1'b1, 10'h030, 32'h2222_2222);
        step();
        check_output("t2_s1_rdv_pulse", 32'(s1_bus.readdatavalid), 32'd0);

        // s1 read with a slow slave: 3 stall cycles, data 4 cycles after accept
        drive_slave(1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            check_output("t3_m0_read_hold", 32'(m0_bus.read),        32'd1);
            check_output("t3_s1_stall",     32'(s1_bus.waitrequest), 32'd1);
            step();
        end
        drive_slave(1'b0, 1'b0, 32'h0);
        #1;
        check_output("t3_m0_read_acc", 32'(m0_bus.read),        32'd1);
        check_output("t3_m0_addr",     32'(m0_bus.address),     32'h3FF);
        check_output("t3_s1_wait_acc", 32'(s1_bus.waitrequest), 32'd0);
        check_output("t3_s0_wait_acc", 32'(s0_bus.waitrequest), 32'd1);
        clear_master(1'b1);
        step();
        check_output("t3_m0_read_drop", 32'(m0_bus.read), 32'd0);
        step();
        step();
        check_output("t3_s1_rdv_early", 32'(s1_bus.readdatavalid), 32'd0);
        step();
        drive_slave(1'b0, 1'b1, 32'hCAFE_F00D);
        step();
        check_output("t3_s1_rdv",   32'(s1_bus.readdatavalid), 32'd1);
        check_output("t3_s1_rdata", s1_bus.readdata,           32'hCAFE_F00D);
        check_output("t3_s0_rdv",   32'(s0_bus.readdatavalid), 32'd0);
        drive_slave(1'b0, 1'b0, 32'h0);

        // Spurious readdatavalid while idle is dropped
        step();
        drive_slave(1'b0, 1'b1, 32'h5555_5555);
        step();
        check_output("t4_s0_rdv",   32'(s0_bus.readdatavalid), 32'd0);
        check_output("t4_s1_rdv",   32'(s1_bus.readdatavalid), 32'd0);
        check_output("t4_s0_rdata", s0_bus.readdata,           32'h1111_1111);
        check_output("t4_s1_rdata", s1_bus.readdata,           32'hCAFE_F00D);
        drive_slave(1'b0, 1'b0, 32'h0);

        // Reset during RDWAIT, late response dropped, then normal service
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'h040, 32'h0, 4'hF, 1'b0);
        step();
        clear_master(1'b0);
        step();
        reset_reset_n = 1'b0;
        #1;
        check_reset_values("t5");
        step();
        drive_slave(1'b0, 1'b1, 32'h7777_7777);
        reset_reset_n = 1'b1;
        step();
        check_output("t5_late_s0_rdv",   32'(s0_bus.readdatavalid), 32'd0);
        check_output("t5_late_s0_rdata", s0_bus.readdata,           32'd0);
        drive_slave(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 10'h055, 32'hAAAA_5555, 4'h3, 1'b0);
        step();
        check_output("t5_m0_write", 32'(m0_bus.write),       32'd1);
        check_output("t5_m0_addr",  32'(m0_bus.address),     32'h055);
        check_output("t5_m0_wdata", m0_bus.writedata,        32'hAAAA_5555);
        check_output("t5_m0_be",    32'(m0_bus.byteenable),  32'h3);
        check_output("t5_s0_wait",  32'(s0_bus.waitrequest), 32'd0);
        clear_master(1'b0);
        step();
        check_output("t5_m0_write_drop", 32'(m0_bus.write), 32'd0);

        // s0 was served last, so a tie now goes to s1 first
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'h0A0, 32'h0, 4'hF, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 10'h0B0, 32'h0, 4'hF, 1'b0);
        step();
        serve_read("t6a", 1'b1, 10'h0B0, 32'h3333_3333);
        step();
        serve_read("t6b", 1'b0, 10'h0A0, 32'h4444_4444);
        step();

`ifdef ARB_TIMEOUT_EN
        // Slave never answers: watchdog returns TIMEOUT_DATA after 16 RDWAIT cycles
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'h100, 32'h0, 4'hF, 1'b0);
        step();
        clear_master(1'b0);
        step();
        for (int i = 0; i < 16; i++) begin
            check_output("t7_s0_rdv_wait", 32'(s0_bus.readdatavalid), 32'd0);
            step();
        end
        check_output("t7_s0_rdv",   32'(s0_bus.readdatavalid), 32'd1);
        check_output("t7_s0_rdata", s0_bus.readdata,           32'hDEAD_BEEF);
        check_output("t7_flag_set", 32'(timeout_flag),         32'd1);
        step();
        check_output("t7_flag_sticky", 32'(timeout_flag), 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'h001, 32'h0000_0001, 4'hF, 1'b0);
        step();
        check_output("t7_flag_before_wr", 32'(timeout_flag), 32'd1);
        clear_master(1'b1);
        step();
        check_output("t7_flag_cleared", 32'(timeout_flag), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
